// File: rtl/attack_encoder.sv
// Per-player attack sequencer: button press -> startup -> active -> cooldown,
// producing the 32-bit attack word consumed by the opponent's damage_coprocessor.
module attack_encoder #(
  parameter int unsigned STARTUP_FRAMES = 3,
  parameter int unsigned ACTIVE_FRAMES  = 4,
  parameter int unsigned A_COOLDOWN     = 8,
  parameter int unsigned B_COOLDOWN     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_a,
  input  logic        btn_b,
  input  logic        stick_up,
  input  logic        stick_down,
  input  logic        stick_left,
  input  logic        stick_right,
  input  logic        hit_detect,
  output logic [31:0] attack,
  output logic        busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_STARTUP  = 2'd1;
  localparam logic [1:0] S_ACTIVE   = 2'd2;
  localparam logic [1:0] S_COOLDOWN = 2'd3;

  localparam logic [4:0] STARTUP_LD = 5'(STARTUP_FRAMES);
  localparam logic [4:0] ACTIVE_LD  = 5'(ACTIVE_FRAMES);
  localparam logic [4:0] A_CD_LD    = 5'(A_COOLDOWN);
  localparam logic [4:0] B_CD_LD    = 5'(B_COOLDOWN);

  // type_q[0]=A, [1]=up-B, [2]=down-B, [3]=left-B, [4]=right-B, [5]=neutral-B
  logic [1:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [5:0] type_q, type_d;
  logic       hit_done_q, hit_done_d;
  logic       strobe_q, strobe_d;
  logic       btn_a_prev_q, btn_a_prev_d;
  logic       btn_b_prev_q, btn_b_prev_d;

  logic       press_a;
  logic       press_b;
  logic       last_tick;
  logic [5:0] b_type;

  assign press_a   = btn_a & ~btn_a_prev_q;
  assign press_b   = btn_b & ~btn_b_prev_q;
  assign last_tick = frame_tick && (cnt_q == 5'd1);

  always_comb begin
    if (stick_up)
      b_type = 6'b000010;
    else if (stick_down)
      b_type = 6'b000100;
    else if (stick_left)
      b_type = 6'b001000;
    else if (stick_right)
      b_type = 6'b010000;
    else
      b_type = 6'b100000;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    type_d       = type_q;
    hit_done_d   = hit_done_q;
    strobe_d     = 1'b0;
    btn_a_prev_d = btn_a;
    btn_b_prev_d = btn_b;

    case (state_q)
      S_IDLE: begin
        if (press_a) begin
          type_d  = 6'b000001;
          cnt_d   = STARTUP_LD;
          state_d = S_STARTUP;
        end else if (press_b) begin
          type_d  = b_type;
          cnt_d   = STARTUP_LD;
          state_d = S_STARTUP;
        end
      end

      S_STARTUP: begin
        if (last_tick) begin
          cnt_d      = ACTIVE_LD;
          hit_done_d = 1'b0;
          state_d    = S_ACTIVE;
        end else if (frame_tick) begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      S_ACTIVE: begin
        // A hit on the final active tick still registers; the strobe then
        // lands in the first cooldown cycle while type bits are still held.
        if (hit_detect && !hit_done_q) begin
          strobe_d   = 1'b1;
          hit_done_d = 1'b1;
        end
        if (last_tick) begin
          cnt_d   = type_q[0] ? A_CD_LD : B_CD_LD;
          state_d = S_COOLDOWN;
        end else if (frame_tick) begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      S_COOLDOWN: begin
        if (last_tick) begin
          cnt_d      = '0;
          type_d     = '0;
          hit_done_d = 1'b0;
          state_d    = S_IDLE;
        end else if (frame_tick) begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      default: begin
        cnt_d      = '0;
        type_d     = '0;
        hit_done_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      type_q       <= '0;
      hit_done_q   <= 1'b0;
      strobe_q     <= 1'b0;
      // History resets high so a button held through reset needs a fresh press.
      btn_a_prev_q <= 1'b1;
      btn_b_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      type_q       <= type_d;
      hit_done_q   <= hit_done_d;
      strobe_q     <= strobe_d;
      btn_a_prev_q <= btn_a_prev_d;
      btn_b_prev_q <= btn_b_prev_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign attack = {21'b0, type_q, 2'b00, busy, (state_q == S_ACTIVE), strobe_q};

endmodule

// File: tb/tb_attack_encoder.sv
// Directed-vector bench for attack_encoder with default frame parameters.
module tb_attack_encoder;

  logic        clock;
  logic        reset;
  logic        frame_tick;
  logic        btn_a;
  logic        btn_b;
  logic        stick_up;
  logic        stick_down;
  logic        stick_left;
  logic        stick_right;
  logic        hit_detect;
  logic [31:0] attack;
  logic        busy;

  int unsigned n_vec;
  int unsigned n_miss;

  attack_encoder #(
    .STARTUP_FRAMES(3),
    .ACTIVE_FRAMES (4),
    .A_COOLDOWN    (8),
    .B_COOLDOWN    (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn_a      (btn_a),
    .btn_b      (btn_b),
    .stick_up   (stick_up),
    .stick_down (stick_down),
    .stick_left (stick_left),
    .stick_right(stick_right),
    .hit_detect (hit_detect),
    .attack     (attack),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic ticks(input int unsigned n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
    end
  endtask

  task automatic do_reset;
    reset       = 1'b1;
    frame_tick  = 1'b0;
    btn_a       = 1'b0;
    btn_b       = 1'b0;
    stick_up    = 1'b0;
    stick_down  = 1'b0;
    stick_left  = 1'b0;
    stick_right = 1'b0;
    hit_detect  = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic press_a;
    btn_a = 1'b1;
    cyc(1);
    btn_a = 1'b0;
  endtask

  logic [3:0]  stick_vec [4];
  logic [31:0] stick_exp [4];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned strobes;
    logic [31:0] first_hit;
    n_vec  = 0;
    n_miss = 0;
    // {up, down, left, right} -> expected word with busy set
    stick_vec[0] = 4'b0110; stick_exp[0] = 32'h0000_0084;
    stick_vec[1] = 4'b0011; stick_exp[1] = 32'h0000_0104;
    stick_vec[2] = 4'b0001; stick_exp[2] = 32'h0000_0204;
    stick_vec[3] = 4'b0000; stick_exp[3] = 32'h0000_0404;

    // 1: A attack timeline
    do_reset;
    check("rst_attack", attack, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    ticks(2);
    check("idle_tick_ignored", attack, 32'h0);
    press_a;
    check("a_type", attack, 32'h24);
    check("a_busy", {31'b0, busy}, 32'h1);
    ticks(2);
    check("a_startup_2ticks", attack, 32'h24);
    ticks(1);
    check("a_active", attack, 32'h26);
    ticks(3);
    check("a_active_last", attack, 32'h26);
    ticks(1);
    check("a_cooldown", attack, 32'h24);
    ticks(7);
    check("a_cooldown_7", attack, 32'h24);
    ticks(1);
    check("a_idle", attack, 32'h0);
    check("a_idle_busy", {31'b0, busy}, 32'h0);

    // 2: up-B wins over left, 16-frame cooldown
    stick_up = 1'b1; stick_left = 1'b1;
    btn_b = 1'b1;
    cyc(1);
    btn_b = 1'b0; stick_up = 1'b0; stick_left = 1'b0;
    check("upb_type", attack, 32'h44);
    ticks(3);
    check("upb_active", attack, 32'h46);
    ticks(4);
    check("upb_cooldown", attack, 32'h44);
    ticks(15);
    check("upb_cooldown_15", attack, 32'h44);
    ticks(1);
    check("upb_idle", attack, 32'h0);

    for (int i = 0; i < 4; i++) begin
      do_reset;
      {stick_up, stick_down, stick_left, stick_right} = stick_vec[i];
      btn_b = 1'b1;
      cyc(1);
      btn_b = 1'b0;
      check($sformatf("b_prio_%0d", i), attack, stick_exp[i]);
    end

    // 3: held hit_detect yields a single strobe
    do_reset;
    press_a;
    ticks(3);
    hit_detect = 1'b1;
    strobes = 0;
    first_hit = '0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (i == 0) first_hit = attack;
      if (attack[0]) strobes++;
    end
    hit_detect = 1'b0;
    check("hit_first_cycle", first_hit, 32'h27);
    check("hit_strobe_count", strobes, 32'd1);
    check("hit_after", attack, 32'h26);
    ticks(4);
    ticks(8);
    check("hit_seq_idle", attack, 32'h0);

    // hit on the final active tick
    do_reset;
    press_a;
    ticks(6);
    check("final_tick_pre", attack, 32'h26);
    hit_detect = 1'b1;
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    hit_detect = 1'b0;
    check("final_tick_strobe", attack, 32'h25);
    cyc(1);
    check("final_tick_after", attack, 32'h24);

    // 4: presses outside IDLE are dropped
    do_reset;
    press_a;
    btn_b = 1'b1; cyc(1); btn_b = 1'b0;
    check("drop_startup", attack, 32'h24);
    ticks(3);
    btn_b = 1'b1; cyc(1); btn_b = 1'b0;
    check("drop_active", attack, 32'h26);
    ticks(4);
    btn_b = 1'b1; cyc(1); btn_b = 1'b0;
    check("drop_cooldown", attack, 32'h24);
    ticks(7);
    btn_a = 1'b1;
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    check("drop_on_exit", attack, 32'h0);
    cyc(2);
    check("drop_on_exit_held", attack, 32'h0);
    btn_a = 1'b0;
    cyc(1);

    reset = 1'b1;
    btn_a = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(3);
    check("held_through_reset", attack, 32'h0);
    btn_a = 1'b0;
    cyc(1);
    press_a;
    check("repress_after_reset", attack, 32'h24);

    // 5: simultaneous A/B, hits outside ACTIVE
    do_reset;
    stick_up = 1'b1;
    btn_a = 1'b1; btn_b = 1'b1;
    cyc(1);
    btn_a = 1'b0; btn_b = 1'b0; stick_up = 1'b0;
    check("ab_same_cycle", attack, 32'h24);
    hit_detect = 1'b1;
    cyc(2);
    check("hit_in_startup", attack, 32'h24);
    ticks(3);
    hit_detect = 1'b0;
    check("startup_hit_active", attack, 32'h26);
    cyc(1);
    check("startup_hit_no_strobe", attack, 32'h26);
    ticks(4);
    hit_detect = 1'b1;
    strobes = 0;
    for (int i = 0; i < 7; i++) begin
      ticks(1);
      if (attack[0]) strobes++;
    end
    check("cooldown_hit_no_strobe", strobes, 32'd0);
    check("cooldown_hit_word", attack, 32'h24);
    ticks(1);
    hit_detect = 1'b0;
    check("cooldown_hit_idle", attack, 32'h0);

    // 6: reset mid-ACTIVE with a hit pending
    do_reset;
    press_a;
    ticks(3);
    hit_detect = 1'b1;
    reset = 1'b1;
    cyc(1);
    check("reset_active_attack", attack, 32'h0);
    check("reset_active_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    hit_detect = 1'b0;
    cyc(1);
    check("reset_active_after", attack, 32'h0);
    press_a;
    check("reset_active_idle_press", attack, 32'h24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
